slice_add_sequencer: RTL and testbench

//  Multi-cycle sequencer that computes an N-bit add/subtract by time-multiplexing
//  one SLICE-bit ripple adder slice, LSB slice first, with a registered carry between

---
 rtl/slice_add_sequencer.sv | 92 +++++++++
 tb/tb_slice_add_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_add_sequencer.sv
// rtl/slice_add_sequencer.sv - N-bit add/subtract computed one SLICE-bit ripple slice per cycle
// Operands accepted on a valid/ready port; result held on a valid/ready port until taken.
module slice_add_sequencer #(
  parameter int N     = 32,
  parameter int SLICE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow,
  output logic         busy
);

  localparam int S  = N / SLICE;
  localparam int IW = (S > 1) ? $clog2(S) : 1;
  localparam logic [IW-1:0] LAST = IW'(S - 1);

  if (N % SLICE != 0) begin : g_bad_slice
    $error("slice_add_sequencer: N must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  a_q, b_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;
  logic [SLICE:0] slice_res;
  logic          accept, last_step;

  assign accept    = in_valid && (state == IDLE);
  assign last_step = (state == RUN) && (idx_q == LAST);
  assign slice_res = {1'b0, a_q[idx_q*SLICE +: SLICE]}
                   + {1'b0, b_q[idx_q*SLICE +: SLICE]}
                   + {{SLICE{1'b0}}, carry_q};

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // b is stored pre-inverted for subtract so the slice datapath is a plain adder
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : c_in;
      idx_q   <= '0;
      sum     <= '0;
    end else if (state == RUN) begin
      sum[idx_q*SLICE +: SLICE] <= slice_res[SLICE-1:0];
      carry_q <= slice_res[SLICE];
      idx_q   <= idx_q + IW'(1);
      if (last_step) begin
        c_out    <= slice_res[SLICE];
        overflow <= (a_q[N-1] == b_q[N-1]) && (slice_res[SLICE-1] != a_q[N-1]);
      end
    end
  end

endmodule

// File: tb/tb_slice_add_sequencer.sv
// tb/tb_slice_add_sequencer.sv - scoreboard bench for slice_add_sequencer
module tb_slice_add_sequencer;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
  } res_t;

  logic        clk = 0;
  logic        rst = 0;
  logic        in_valid = 0, in_ready;
  logic [31:0] a = 0, b = 0;
  logic        c_in = 0, sub = 0;
  logic        out_valid, out_ready = 0;
  logic [31:0] sum;
  logic        c_out, overflow, busy;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  res_t sb[$];

  slice_add_sequencer #(.N(32), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t ref_model(input logic [31:0] ta, input logic [31:0] tb_,
                                     input logic tc, input logic ts);
    res_t r;
    logic [32:0] w;
    if (ts) begin
      w   = {1'b0, ta} + {1'b0, ~tb_} + 33'd1;
      r.v = (ta[31] != tb_[31]) && (w[31] != ta[31]);
    end else begin
      w   = {1'b0, ta} + {1'b0, tb_} + {32'd0, tc};
      r.v = (ta[31] == tb_[31]) && (w[31] != ta[31]);
    end
    r.s = w[31:0];
    r.c = w[32];
    return r;
  endfunction

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_,
                      input logic tc, input logic ts, output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      a = ta; b = tb_; c_in = tc; sub = ts; in_valid = 1;
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid   = 0;
        accept_cyc = cyc;
        sb.push_back(ref_model(ta, tb_, tc, ts));
        ok = 1;
        break;
      end
    end
    in_valid = 0;
  endtask

  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    ok  = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
  endtask

  task automatic run_one(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                         input logic ts, output res_t got, output res_t exp,
                         output int lat, output bit ok);
    bit sok, wok;
    send(ta, tb_, tc, ts, sok);
    wait_out(lat, wok);
    got = {sum, c_out, overflow};
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    ok  = sok && wok;
    if (ok) take();
  endtask

  task automatic test_reset();
    rst = 0;
    #12;
    vectors++;
    if ({out_valid, sum, c_out, overflow, busy} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ov=%b sum=%h c=%b v=%b busy=%b want all 0",
               out_valid, sum, c_out, overflow, busy);
    end
    @(negedge clk);
    rst = 1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  task automatic test_add_wrap();
    res_t got, exp; int lat; bit ok;
    run_one(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, got, exp, lat, ok);
    vectors++;
    if (!ok || got !== exp || exp !== {32'h0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL add_wrap: got %h/%b/%b want 00000000/1/0 (ok=%0d)", got.s, got.c, got.v, ok);
    end
    vectors++;
    if (lat != 8) begin
      miscompares++;
      $display("FAIL add_latency: got %0d edges want 8", lat);
    end
  endtask

  task automatic test_sub();
    res_t got, exp; int lat; bit ok;
    run_one(32'd5, 32'd7, 1'b1, 1'b1, got, exp, lat, ok);
    vectors++;
    if (!ok || got !== exp || exp !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL sub_5_7: got %h/%b/%b want fffffffe/0/0", got.s, got.c, got.v);
    end
    run_one(32'd7, 32'd5, 1'b0, 1'b1, got, exp, lat, ok);
    vectors++;
    if (!ok || got !== exp || exp !== {32'd2, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL sub_7_5: got %h/%b/%b want 00000002/1/0", got.s, got.c, got.v);
    end
  endtask

  task automatic test_overflow();
    res_t got, exp; int lat; bit ok;
    run_one(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, got, exp, lat, ok);
    vectors++;
    if (!ok || got !== exp || exp !== {32'h8000_0000, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL ovf_add: got %h/%b/%b want 80000000/0/1", got.s, got.c, got.v);
    end
    run_one(32'h8000_0000, 32'd1, 1'b0, 1'b1, got, exp, lat, ok);
    vectors++;
    if (!ok || got !== exp || exp !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL ovf_sub: got %h/%b/%b want 7fffffff/1/1", got.s, got.c, got.v);
    end
  endtask

  task automatic test_backpressure();
    res_t got, exp; int lat; bit sok, wok, seen;
    send(32'hFFFF_0000, 32'h0002_0000, 1'b0, 1'b0, sok);
    wait_out(lat, wok);
    got = {sum, c_out, overflow};
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (!sok || !wok || got !== exp) begin
      miscompares++;
      $display("FAIL bp_result: got %h/%b/%b want %h/%b/%b", got.s, got.c, got.v, exp.s, exp.c, exp.v);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~i[0];
      a = $urandom; b = $urandom; c_in = 1; sub = i[1];
      @(posedge clk);
      #1;
      vectors++;
      if ({out_valid, in_ready, sum, c_out, overflow} !== {1'b1, 1'b0, exp}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got ov=%b rdy=%b %h/%b/%b want 1/0 %h/%b/%b", i,
                 out_valid, in_ready, sum, c_out, overflow, exp.s, exp.c, exp.v);
      end
    end
    @(negedge clk);
    in_valid = 0;
    take();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got ov=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen = 1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL bp_no_accept: got spurious operation want none");
    end
  endtask

  task automatic test_reset_midop();
    res_t got, exp; int lat; bit sok, ok, seen;
    send(32'd3, 32'd4, 1'b1, 1'b0, sok);
    void'(sb.pop_back());
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 0;
    #1;
    vectors++;
    if ({out_valid, sum, c_out, overflow} !== 35'd0 || !sok) begin
      miscompares++;
      $display("FAIL rst_midop: got ov=%b sum=%h c=%b v=%b want 0/00000000/0/0",
               out_valid, sum, c_out, overflow);
    end
    @(negedge clk);
    rst = 1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen = 1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL rst_abort: got result from aborted op want none");
    end
    run_one(32'd3, 32'd4, 1'b1, 1'b0, got, exp, lat, ok);
    vectors++;
    if (!ok || got !== exp || exp !== {32'd8, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_next: got %h/%b/%b want 00000008/0/0", got.s, got.c, got.v);
    end
  endtask

  task automatic test_back_to_back();
    res_t got, exp; int lat, prev; bit sok, wok;
    logic [31:0] ta, tb_;
    logic tc, ts;
    out_ready = 1;
    prev = 0;
    for (int i = 0; i < 100; i++) begin
      ta = $urandom;
      tb_ = $urandom;
      tc = 1'($urandom);
      ts = 1'($urandom);
      if (i < 4) begin
        ta = (i[0]) ? 32'h8000_0000 : 32'hFFFF_FFFF;
        tb_ = (i[1]) ? 32'h7FFF_FFFF : 32'h8000_0000;
      end
      send(ta, tb_, tc, ts, sok);
      if (i > 0) begin
        vectors++;
        if (accept_cyc - prev != 10) begin
          miscompares++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles want 10", i, accept_cyc - prev);
        end
      end
      prev = accept_cyc;
      wait_out(lat, wok);
      got = {sum, c_out, overflow};
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      vectors++;
      if (!sok || !wok || got !== exp) begin
        miscompares++;
        $display("FAIL b2b[%0d]: a=%h b=%h c=%b sub=%b got %h/%b/%b want %h/%b/%b", i, ta, tb_,
                 tc, ts, got.s, got.c, got.v, exp.s, exp.c, exp.v);
      end
    end
    out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_overflow();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
